// File: rtl/adc_trig_capture_if.sv
// Bundle of ADC capture data, control and readout signals between a driver and the capture block.
// Latency: none (wires only).
// Backpressure: none; readout is paced by rdreq and gated by empty.
// Ports: AD_Data/ad_valid sample stream; Trigger/trig_slope/auto_mode/force_trig trigger setup;
//        start arm request; rdreq read pop; cap_done/empty/q/trig_forced status and read data.
interface adc_trig_capture_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] AD_Data;
  logic              ad_valid;
  logic [DATA_W-1:0] Trigger;
  logic              trig_slope;
  logic              auto_mode;
  logic              force_trig;
  logic              start;
  logic              rdreq;
  logic              cap_done;
  logic              empty;
  logic [DATA_W-1:0] q;
  logic              trig_forced;

  modport master (
    output AD_Data, ad_valid, Trigger, trig_slope, auto_mode, force_trig, start, rdreq,
    input  cap_done, empty, q, trig_forced
  );

  modport slave (
    input  AD_Data, ad_valid, Trigger, trig_slope, auto_mode, force_trig, start, rdreq,
    output cap_done, empty, q, trig_forced
  );
endinterface

// File: rtl/adc_trig_capture.sv
// Triggered ADC capture into a DEPTH-deep circular buffer with PRE_DEPTH pre-trigger samples.
// Latency: all status outputs registered; q follows an accepted rdreq by one clock.
// Backpressure: none on the sample stream; reads while empty are ignored.
// Ports: Clk, Reset (sync, active-high); bus (slave modport) carries sample input, trigger
//        controls, start, rdreq, and the cap_done/empty/q/trig_forced outputs.
module adc_trig_capture #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 1024,
  parameter int PRE_DEPTH    = 256,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic               Clk,
  input  logic               Reset,
  adc_trig_capture_if.slave  bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int TW     = $clog2(AUTO_TIMEOUT + 1);
  localparam int POST_N = DEPTH - PRE_DEPTH - 1;

  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_DEPTH);
  localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH - 1);
  localparam logic [TW-1:0] TMO       = TW'(AUTO_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     ta_q, ta_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic              force_pend_q, force_pend_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              cap_done_q, cap_done_d;
  logic              empty_q, empty_d;
  logic              trig_forced_q, trig_forced_d;

  logic              wr_en;
  logic              edge_hit;
  logic              forced_hit;
  logic              enter_done;
  logic              start_cap;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    ta_d          = ta_q;
    rp_d          = rp_q;
    cnt_d         = cnt_q;
    rcnt_d        = rcnt_q;
    tmo_d         = tmo_q;
    prev_d        = prev_q;
    prev_ok_d     = prev_ok_q;
    force_pend_d  = force_pend_q;
    q_d           = q_q;
    cap_done_d    = cap_done_q;
    empty_d       = empty_q;
    trig_forced_d = trig_forced_q;
    wr_en         = 1'b0;
    edge_hit      = 1'b0;
    forced_hit    = 1'b0;
    enter_done    = 1'b0;
    start_cap     = 1'b0;

    case (state_q)
      S_IDLE: start_cap = bus.start;

      S_PREFILL: begin
        if (bus.ad_valid) begin
          wr_en = 1'b1;
          wp_d  = wp_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PRE_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end
        end
      end

      S_ARMED: begin
        // A force request waits here until a valid sample arrives to carry it.
        force_pend_d = force_pend_q | bus.force_trig;
        if (bus.ad_valid) begin
          wr_en     = 1'b1;
          wp_d      = wp_q + 1'b1;
          prev_d    = bus.AD_Data;
          prev_ok_d = 1'b1;
          // prev_ok_q keeps the first ARMED sample from comparing against a PREFILL sample.
          if (bus.trig_slope)
            edge_hit = prev_ok_q && (prev_q >= bus.Trigger) && (bus.AD_Data < bus.Trigger);
          else
            edge_hit = prev_ok_q && (prev_q <= bus.Trigger) && (bus.AD_Data > bus.Trigger);
          forced_hit = force_pend_q | bus.force_trig | (bus.auto_mode & (tmo_q == TMO));
          if (edge_hit || forced_hit) begin
            ta_d          = wp_q;
            trig_forced_d = ~edge_hit;   // a genuine edge wins over a coincident force
            force_pend_d  = 1'b0;
            cnt_d         = '0;
            if (POST_N == 0) enter_done = 1'b1;
            else             state_d    = S_POST;
          end else if (tmo_q != TMO) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      S_POST: begin
        if (bus.ad_valid) begin
          wr_en = 1'b1;
          wp_d  = wp_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == POST_LAST) enter_done = 1'b1;
        end
      end

      S_DONE: begin
        // A new arm request aborts any readout still in progress.
        if (bus.start) begin
          start_cap = 1'b1;
        end else if (bus.rdreq && !empty_q) begin
          q_d    = mem[rp_q];
          rp_d   = rp_q + 1'b1;
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == RD_LAST) empty_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (enter_done) begin
      state_d    = S_DONE;
      cap_done_d = 1'b1;
      empty_d    = 1'b0;
      // Oldest kept sample sits PRE_DEPTH slots behind the trigger; wraps mod DEPTH.
      rp_d       = ta_d - PRE_OFS;
      rcnt_d     = '0;
    end

    if (start_cap) begin
      state_d      = S_PREFILL;
      wp_d         = '0;
      cnt_d        = '0;
      rcnt_d       = '0;
      rp_d         = '0;
      tmo_d        = '0;
      prev_ok_d    = 1'b0;
      force_pend_d = 1'b0;
      cap_done_d   = 1'b0;
      empty_d      = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      wp_q          <= '0;
      ta_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
      rcnt_q        <= '0;
      tmo_q         <= '0;
      prev_q        <= '0;
      prev_ok_q     <= 1'b0;
      force_pend_q  <= 1'b0;
      q_q           <= '0;
      cap_done_q    <= 1'b0;
      empty_q       <= 1'b1;
      trig_forced_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      ta_q          <= ta_d;
      rp_q          <= rp_d;
      cnt_q         <= cnt_d;
      rcnt_q        <= rcnt_d;
      tmo_q         <= tmo_d;
      prev_q        <= prev_d;
      prev_ok_q     <= prev_ok_d;
      force_pend_q  <= force_pend_d;
      q_q           <= q_d;
      cap_done_q    <= cap_done_d;
      empty_q       <= empty_d;
      trig_forced_q <= trig_forced_d;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) mem[wp_q] <= bus.AD_Data;
  end

  assign bus.cap_done    = cap_done_q;
  assign bus.empty       = empty_q;
  assign bus.q           = q_q;
  assign bus.trig_forced = trig_forced_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Self-checking bench for adc_trig_capture: directed scenarios plus random traffic vs a sample-history model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_adc_trig_capture;
  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int ATO    = 8;
  localparam int POST_N = DEPTH - PRE - 1;

  localparam int P_IDLE = 0, P_PREFILL = 1, P_ARMED = 2, P_POST = 3, P_DONE = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  adc_trig_capture_if #(.DATA_W(DW)) bus();

  adc_trig_capture #(
    .DATA_W(DW), .DEPTH(DEPTH), .PRE_DEPTH(PRE), .AUTO_TIMEOUT(ATO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: full history of valid samples accepted since the last start.
  int        hist[$];
  int        trig_pos;
  bit        started;
  int        reads;
  logic [7:0] exp_q;
  bit        exp_forced;
  bit        pend;

  int        ramp_v, n_samp, n_cyc;
  logic [7:0] rd[$];

  function automatic int phase();
    if (!started)                             return P_IDLE;
    if (hist.size() < PRE)                    return P_PREFILL;
    if (trig_pos < 0)                         return P_ARMED;
    if (hist.size() < trig_pos + POST_N + 1)  return P_POST;
    return P_DONE;
  endfunction

  task automatic model_update();
    int  ph, armed_n, prev, d, t;
    bit  edge_h, forced_h;
    if (Reset) begin
      started = 0; hist.delete(); trig_pos = -1; reads = 0;
      exp_q = 8'h00; exp_forced = 0; pend = 0;
      return;
    end
    ph = phase();
    d  = int'(bus.AD_Data);
    t  = int'(bus.Trigger);
    if (bus.start && (ph == P_IDLE || ph == P_DONE)) begin
      started = 1; hist.delete(); trig_pos = -1; reads = 0; pend = 0;
    end else begin
      case (ph)
        P_PREFILL, P_POST: if (bus.ad_valid) hist.push_back(d);
        P_ARMED: begin
          pend = pend | bus.force_trig;
          if (bus.ad_valid) begin
            armed_n  = hist.size() - PRE;
            prev     = hist[hist.size() - 1];
            edge_h   = (armed_n > 0) && (bus.trig_slope ? (prev >= t && d < t) : (prev <= t && d > t));
            forced_h = pend || (bus.auto_mode && armed_n >= ATO);
            hist.push_back(d);
            if (edge_h || forced_h) begin
              trig_pos = hist.size() - 1; exp_forced = !edge_h; pend = 0;
            end
          end
        end
        P_DONE: if (bus.rdreq && reads < DEPTH) begin
          exp_q = 8'(hist[trig_pos - PRE + reads]); reads++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge Clk);
    #1;
    chk("cap_done",    bus.cap_done,    phase() == P_DONE);
    chk("empty",       bus.empty,       !(phase() == P_DONE && reads < DEPTH));
    chk("q",           bus.q,           exp_q);
    chk("trig_forced", bus.trig_forced, exp_forced);
    bus.start      = 1'b0;
    bus.force_trig = 1'b0;
  endtask

  task automatic arm(input int first_val);
    ramp_v       = first_val;
    bus.start    = 1'b1;
    bus.ad_valid = 1'b0;
    tick();
  endtask

  // Feeds a ramp until the DUT reports cap_done, stop_at samples, or the cycle budget runs out.
  task automatic run(input bit toggle, input int step, input int force_at, input int restart_at, input int stop_at);
    n_samp = 0; n_cyc = 0;
    while (!bus.cap_done && n_samp < stop_at && n_cyc < 600) begin
      bus.ad_valid = toggle ? ((n_cyc % 2) == 0) : 1'b1;
      if (bus.ad_valid) begin
        bus.AD_Data    = 8'(ramp_v);
        bus.force_trig = (n_samp == force_at);
        bus.start      = (n_samp == restart_at);
        ramp_v += step;
        n_samp++;
      end else begin
        bus.AD_Data = 8'($urandom);
      end
      tick();
      n_cyc++;
    end
    bus.ad_valid = 1'b0;
  endtask

  task automatic read_n(input int n);
    rd.delete();
    for (int i = 0; i < n; i++) begin
      bus.rdreq = 1'b1;
      tick();
      rd.push_back(bus.q);
    end
    bus.rdreq = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.AD_Data = '0; bus.ad_valid = 0; bus.Trigger = '0; bus.trig_slope = 0;
    bus.auto_mode = 0; bus.force_trig = 0; bus.start = 0; bus.rdreq = 0;
    started = 0; trig_pos = -1; reads = 0; exp_q = 0; exp_forced = 0; pend = 0;

    // Reset dominates start/force/rdreq.
    Reset = 1'b1; bus.start = 1; bus.force_trig = 1; bus.rdreq = 1;
    tick(); tick();
    Reset = 1'b0; bus.rdreq = 0;
    tick();

    // Rising ramp, trigger at 20.
    bus.Trigger = 8'd20; bus.trig_slope = 0; bus.auto_mode = 0;
    arm(0);
    run(0, 1, -1, -1, 1000);
    chk("r37_cap_done", bus.cap_done, 1);
    chk("r37_nsamp", n_samp, 33);
    read_n(DEPTH);
    for (int k = 0; k < DEPTH; k++) chk("r37_rd", rd[k], 17 + k);
    bus.rdreq = 1; tick(); bus.rdreq = 0;
    chk("r37_empty_hold", bus.q, 32);

    // Same ramp with ad_valid toggling.
    arm(0);
    run(1, 1, -1, -1, 1000);
    chk("r40_nsamp", n_samp, 33);
    chk("r40_ncyc", n_cyc, 65);
    read_n(DEPTH);
    chk("r40_rd_first", rd[0], 17);
    chk("r40_rd_last", rd[DEPTH-1], 32);

    // Falling slope from 200, trigger 100.
    bus.Trigger = 8'd100; bus.trig_slope = 1;
    arm(200);
    run(0, -1, -1, -1, 1000);
    chk("r38_nsamp", n_samp, 113);
    chk("r38_forced", bus.trig_forced, 0);
    read_n(DEPTH);
    chk("r38_rd0", rd[0], 103);
    chk("r38_rd4", rd[4], 99);
    chk("r38_rd15", rd[15], 88);

    // Constant data, auto timeout.
    bus.Trigger = 8'd50; bus.trig_slope = 0; bus.auto_mode = 1;
    arm(50);
    run(0, 0, -1, -1, 1000);
    chk("r39_nsamp", n_samp, PRE + ATO + 1 + POST_N);
    chk("r39_forced", bus.trig_forced, 1);
    bus.auto_mode = 0;
    arm(50);
    run(0, 0, -1, -1, 100);
    chk("r39_noauto_empty", bus.empty, 1);
    chk("r39_noauto_done", bus.cap_done, 0);
    run(0, 0, 0, -1, 1000);
    chk("force_nsamp", n_samp, 1 + POST_N);
    chk("force_forced", bus.trig_forced, 1);

    // Edge and force on the same sample: edge wins.
    bus.Trigger = 8'd20;
    arm(0);
    run(0, 1, 21, -1, 1000);
    chk("edgeforce_forced", bus.trig_forced, 0);
    chk("edgeforce_nsamp", n_samp, 33);
    // Force during PREFILL is ignored.
    arm(0);
    run(0, 1, 1, -1, 1000);
    chk("prefill_force_nsamp", n_samp, 33);

    // Reset in POST.
    arm(0);
    run(0, 1, -1, -1, 25);
    Reset = 1; bus.rdreq = 1; bus.start = 1; bus.force_trig = 1;
    tick();
    Reset = 0; bus.rdreq = 0;
    chk("r41_post_empty", bus.empty, 1);
    chk("r41_post_done", bus.cap_done, 0);
    bus.rdreq = 1; tick(); bus.rdreq = 0;
    chk("r41_rd_on_empty", bus.q, 0);
    // Reset at read 5 of DONE.
    arm(0);
    run(0, 1, -1, -1, 1000);
    read_n(5);
    chk("r41_rd4", rd[4], 21);
    Reset = 1; tick(); Reset = 0;
    chk("r41_done_empty", bus.empty, 1);
    chk("r41_done_done", bus.cap_done, 0);
    chk("r41_done_q", bus.q, 0);

    // Start in ARMED ignored; start at DONE after 3 reads re-arms.
    arm(0);
    run(0, 1, -1, 8, 1000);
    chk("r42_nsamp", n_samp, 33);
    read_n(3);
    chk("r42_rd2", rd[2], 19);
    bus.Trigger = 8'd110;
    arm(100);
    chk("r42_rearm_empty", bus.empty, 1);
    chk("r42_rearm_done", bus.cap_done, 0);
    run(0, 1, -1, -1, 1000);
    chk("r42_nsamp2", n_samp, 23);
    read_n(DEPTH);
    chk("r42_rd0", rd[0], 107);
    chk("r42_rd15", rd[15], 122);

    // Random traffic against the model.
    w = 128;
    for (int c = 0; c < 3000; c++) begin
      Reset          = ($urandom_range(299, 0) == 0);
      bus.start      = ($urandom_range(49, 0) == 0);
      bus.force_trig = ($urandom_range(79, 0) == 0);
      bus.rdreq      = 1'($urandom_range(1, 0));
      bus.ad_valid   = ($urandom_range(3, 0) != 0);
      w = (w + int'($urandom_range(24, 0)) - 12) & 255;
      bus.AD_Data = 8'(w);
      if ($urandom_range(99, 0) == 0)  bus.Trigger    = 8'($urandom);
      if ($urandom_range(199, 0) == 0) bus.trig_slope = ~bus.trig_slope;
      if ($urandom_range(299, 0) == 0) bus.auto_mode  = ~bus.auto_mode;
      tick();
    end
    Reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_trig_capture.md
ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ADC sample width.
REQ-002 SHALL have parameter DEPTH, default 1024, samples per capture; power of two, 16..8192.
REQ-003 SHALL have parameter PRE_DEPTH, default 256, pre-trigger samples kept; 1..DEPTH-1.
REQ-004 SHALL have parameter AUTO_TIMEOUT, default 4096, samples in ARMED before auto-mode forced trigger.
REQ-005 SHALL have ports: Clk  in  1  sole clock, rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 AD_Data  in  DATA_W  ADC sample.
REQ-008 ad_valid  in  1  AD_Data valid this cycle.
REQ-009 Trigger  in  DATA_W  trigger level, sampled every cycle.
REQ-010 trig_slope  in  1  0 = rising, 1 = falling.
REQ-011 auto_mode  in  1  1 = force trigger after AUTO_TIMEOUT.
REQ-012 force_trig  in  1  one-cycle immediate trigger request.
REQ-013 start  in  1  one-cycle arm request.
REQ-014 rdreq  in  1  read one sample.
REQ-015 cap_done  out  1  capture complete, buffer readable.
REQ-016 empty  out  1  no unread samples.
REQ-017 q  out  DATA_W  read data.
REQ-018 trig_forced  out  1  last capture triggered by timeout or force_trig.

Function
REQ-019 SHALL implement states IDLE, PREFILL, ARMED, POST, DONE; internal DEPTH x DATA_W circular buffer with write pointer wp.
REQ-020 IDLE/DONE + start -> PREFILL; wp, sample counter and read state cleared; cap_done=0, empty=1. start in any other state ignored.
REQ-021 PREFILL: each ad_valid writes AD_Data at wp, wp+1 mod DEPTH; after PRE_DEPTH writes -> ARMED.
REQ-022 ARMED: each ad_valid writes and advances wp (overwrites oldest); prev sample held in a register loaded only on ad_valid.
REQ-023 Rising trigger SHALL be prev <= Trigger and AD_Data > Trigger on a valid sample; falling SHALL be prev >= Trigger and AD_Data < Trigger; unsigned compare.
REQ-024 First valid sample in ARMED SHALL NOT trigger (no prev yet qualified in ARMED).
REQ-025 On trigger, the triggering sample SHALL be written, trig address ta = its wp, -> POST.
REQ-026 auto_mode=1 and AUTO_TIMEOUT valid samples written in ARMED without edge -> trigger on the next valid sample, trig_forced=1.
REQ-027 force_trig in ARMED -> trigger on next valid sample, trig_forced=1; force_trig in other states ignored; edge and force same sample -> trig_forced=0.
REQ-028 POST: write DEPTH-PRE_DEPTH-1 further valid samples, then -> DONE, cap_done=1 registered same cycle as state entry.
REQ-029 Read start address SHALL be (ta - PRE_DEPTH) mod DEPTH; samples read oldest first, exactly DEPTH of them.
REQ-030 empty SHALL be 1 in all states except DONE; in DONE, 1 after DEPTH reads.
REQ-031 rdreq with empty=0: q updated on next rising edge (1-cycle latency), held otherwise; rdreq with empty=1 ignored, q unchanged.
REQ-032 Samples with ad_valid=0 SHALL NOT be written, counted, or evaluated for trigger in any state.
REQ-033 start in DONE SHALL abort any unfinished readout and begin a new capture.
REQ-034 Trigger and trig_slope changes SHALL take effect on the next valid sample.

Reset
REQ-035 Reset=1 SHALL force IDLE, cap_done=0, empty=1, q=0, trig_forced=0, wp=0, counters=0, at any time including mid-capture or mid-readout; buffer contents not cleared.
REQ-036 Reset SHALL dominate start, force_trig and rdreq in the same cycle.

Verification
REQ-037 DEPTH=16, PRE=4, ramp 0,1,2,... ad_valid=1, Trigger=20, rising -> trigger on sample 21; readout 17..32, cap_done after 11 POST samples.
REQ-038 Falling slope, data 200 down to 0 step 1, Trigger=100 -> first read sample 103, trig at read index 4 = 99.
REQ-039 Constant data 50, auto_mode=1, AUTO_TIMEOUT=8 -> trigger after 8 ARMED samples, trig_forced=1; auto_mode=0 -> stays ARMED indefinitely.
REQ-040 ad_valid toggling 1/0 during ramp -> same readout as REQ-037, capture takes twice the cycles.
REQ-041 Reset asserted in POST and at read 5 of DONE -> IDLE, empty=1, cap_done=0 next cycle; rdreq on empty -> q unchanged.
REQ-042 start during ARMED ignored; start at DONE after 3 reads -> PREFILL, empty=1, new capture correct.
